mdp3_group_parser: RTL and testbench

- Parametrised successor to the fixed 5-beat MDP3 parser.
- Parses an MDP3 incremental-refresh message carried as 64-bit beats: one group-header beat, then NumInGroup repeating entries of 4 beats (32 bytes) each.
- Emits one decoded, endian-corrected entry record per entry through an output FIFO with valid/ready backpressure, toward the order book.
- Detects framing errors and resynchronises on the next start-of-packet.

---
 rtl/mdp3_group_parser.sv | 259 +++++++++++++++++++++++++
 tb/tb_mdp3_group_parser.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdp3_group_parser.sv
// MDP3 incremental-refresh group parser: header beat + N x 4-beat entries -> decoded records
// through a show-ahead output FIFO. Optional SECID filter enabled by MDP3_SECID_FILTER_EN.
module mdp3_group_parser #(
    parameter int unsigned MAX_ENTRIES = 16,
    parameter int unsigned OUT_DEPTH   = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_sop,
    input  logic                           in_eop,
    input  logic [63:0]                    in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [63:0]                    out_price,
    output logic [31:0]                    out_qty,
    output logic [31:0]                    out_secid,
    output logic [31:0]                    out_rptseq,
    output logic [31:0]                    out_norders,
    output logic [7:0]                     out_level,
    output logic [1:0]                     out_action,
    output logic [7:0]                     out_etype,
    output logic [$clog2(MAX_ENTRIES)-1:0] out_idx,
    output logic                           out_last,
`ifdef MDP3_SECID_FILTER_EN
    input  logic                           cfg_filt_en,
    input  logic [31:0]                    cfg_secid,
    output logic [CNT_W-1:0]               filt_count,
`endif
    output logic                           err_pulse,
    output logic [CNT_W-1:0]               err_count,
    output logic [CNT_W-1:0]               msg_count
);

    localparam int unsigned IDX_W  = $clog2(MAX_ENTRIES);
    localparam int unsigned PTR_W  = $clog2(OUT_DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StEntry, StDrain} state_t;

    typedef struct packed {
        logic [63:0]      price;
        logic [31:0]      qty;
        logic [31:0]      secid;
        logic [31:0]      rptseq;
        logic [31:0]      norders;
        logic [7:0]       level;
        logic [1:0]       action;
        logic [7:0]       etype;
        logic [IDX_W-1:0] idx;
        logic             last;
    } rec_t;

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [63:0] swap64(input logic [63:0] x);
        return {swap32(x[31:0]), swap32(x[63:32])};
    endfunction

    state_t           state;
    logic [1:0]       beat;
    logic [IDX_W-1:0] idx;
    logic [7:0]       num;
    logic [63:0]      h_price;
    logic [31:0]      h_qty;
    logic [31:0]      h_secid;
    logic [31:0]      h_rptseq;
    logic [31:0]      h_norders;

    rec_t              mem [OUT_DEPTH];
    rec_t              head;
    rec_t              wr_rec;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] fill;

    logic        fifo_full;
    logic        accept;
    logic        last_entry;
    logic        wr_entry;
    logic        keep;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] hdr_blen;
    logic [7:0]  hdr_n;
    logic        hdr_bad;

    // Stall only the beat that writes the FIFO; a read this cycle is not credited until next cycle.
    assign fifo_full  = (fill == FILL_W'(OUT_DEPTH));
    assign in_ready   = !(state == StEntry && beat == 2'd3 && fifo_full);
    assign accept     = in_valid && in_ready;

    assign hdr_blen   = {in_data[55:48], in_data[63:56]};
    assign hdr_n      = in_data[47:40];
    assign hdr_bad    = (hdr_blen != 16'd32) || (32'(hdr_n) > MAX_ENTRIES);
    assign last_entry = (8'(idx) == num - 8'd1);

    assign wr_entry   = accept && !in_sop && state == StEntry && beat == 2'd3;
`ifdef MDP3_SECID_FILTER_EN
    assign keep       = !cfg_filt_en || (h_secid == cfg_secid);
`else
    assign keep       = 1'b1;
`endif
    assign wr_en      = wr_entry && keep;
    assign rd_en      = out_valid && out_ready;

    always_comb begin
        wr_rec         = '0;
        wr_rec.price   = h_price;
        wr_rec.qty     = h_qty;
        wr_rec.secid   = h_secid;
        wr_rec.rptseq  = h_rptseq;
        wr_rec.norders = h_norders;
        wr_rec.level   = in_data[63:56];
        wr_rec.action  = in_data[49:48];
        wr_rec.etype   = in_data[47:40];
        wr_rec.idx     = idx;
        wr_rec.last    = last_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            beat       <= '0;
            idx        <= '0;
            num        <= '0;
            h_price    <= '0;
            h_qty      <= '0;
            h_secid    <= '0;
            h_rptseq   <= '0;
            h_norders  <= '0;
            err_pulse  <= 1'b0;
            msg_count  <= '0;
`ifdef MDP3_SECID_FILTER_EN
            filt_count <= '0;
`endif
        end else begin
            err_pulse <= 1'b0;
            if (accept) begin
                if (in_sop) begin
                    // A header outside IDLE aborts the current message and restarts on this beat.
                    if (state != StIdle) err_pulse <= 1'b1;
                    beat <= '0;
                    idx  <= '0;
                    num  <= hdr_n;
                    if (hdr_bad) begin
                        err_pulse <= 1'b1;
                        state     <= in_eop ? StIdle : StDrain;
                    end else if (hdr_n == 8'd0) begin
                        if (in_eop) begin
                            msg_count <= msg_count + CNT_W'(1);
                            state     <= StIdle;
                        end else begin
                            err_pulse <= 1'b1;
                            state     <= StDrain;
                        end
                    end else begin
                        state <= StEntry;
                    end
                end else begin
                    case (state)
                        StEntry: begin
                            case (beat)
                                2'd0: h_price <= swap64(in_data);
                                2'd1: begin
                                    h_qty   <= swap32(in_data[63:32]);
                                    h_secid <= swap32(in_data[31:0]);
                                end
                                2'd2: begin
                                    h_rptseq  <= swap32(in_data[63:32]);
                                    h_norders <= swap32(in_data[31:0]);
                                end
                                default: ;
                            endcase
                            if (beat != 2'd3) begin
                                if (in_eop) begin
                                    err_pulse <= 1'b1;
                                    state     <= StIdle;
                                end else begin
                                    beat <= beat + 2'd1;
                                end
                            end else begin
                                beat <= '0;
`ifdef MDP3_SECID_FILTER_EN
                                if (!keep) filt_count <= filt_count + CNT_W'(1);
`endif
                                if (last_entry) begin
                                    if (in_eop) begin
                                        msg_count <= msg_count + CNT_W'(1);
                                        state     <= StIdle;
                                    end else begin
                                        err_pulse <= 1'b1;
                                        state     <= StDrain;
                                    end
                                end else if (in_eop) begin
                                    err_pulse <= 1'b1;
                                    state     <= StIdle;
                                end else begin
                                    idx <= idx + IDX_W'(1);
                                end
                            end
                        end
                        StDrain: begin
                            if (in_eop) state <= StIdle;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (err_pulse && err_count != '1) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

    // Registered write, show-ahead read: a record is visible the cycle after its last beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_rec;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !rd_en) begin
                fill <= fill + FILL_W'(1);
            end else if (!wr_en && rd_en) begin
                fill <= fill - FILL_W'(1);
            end
        end
    end

    assign head        = mem[rd_ptr];
    assign out_valid   = (fill != '0);
    assign out_price   = head.price;
    assign out_qty     = head.qty;
    assign out_secid   = head.secid;
    assign out_rptseq  = head.rptseq;
    assign out_norders = head.norders;
    assign out_level   = head.level;
    assign out_action  = head.action;
    assign out_etype   = head.etype;
    assign out_idx     = head.idx;
    assign out_last    = head.last;

endmodule

// File: tb/tb_mdp3_group_parser.sv
// Directed bench for mdp3_group_parser: header vector table, entry decode table, and
// hand-written sequences for backpressure, early eop, mid-message sop and reset.
module tb_mdp3_group_parser;

    localparam int unsigned MAX_ENTRIES = 16;
    localparam int unsigned OUT_DEPTH   = 4;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned IDX_W       = $clog2(MAX_ENTRIES);

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready, in_sop, in_eop;
    logic [63:0]      in_data;
    logic             out_valid, out_ready;
    logic [63:0]      out_price;
    logic [31:0]      out_qty, out_secid, out_rptseq, out_norders;
    logic [7:0]       out_level, out_etype;
    logic [1:0]       out_action;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count, msg_count;
`ifdef MDP3_SECID_FILTER_EN
    logic             cfg_filt_en;
    logic [31:0]      cfg_secid;
    logic [CNT_W-1:0] filt_count;
`endif

    always #5 clk = ~clk;

    mdp3_group_parser #(
        .MAX_ENTRIES(MAX_ENTRIES),
        .OUT_DEPTH  (OUT_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_price  (out_price),
        .out_qty    (out_qty),
        .out_secid  (out_secid),
        .out_rptseq (out_rptseq),
        .out_norders(out_norders),
        .out_level  (out_level),
        .out_action (out_action),
        .out_etype  (out_etype),
        .out_idx    (out_idx),
        .out_last   (out_last),
`ifdef MDP3_SECID_FILTER_EN
        .cfg_filt_en(cfg_filt_en),
        .cfg_secid  (cfg_secid),
        .filt_count (filt_count),
`endif
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .msg_count  (msg_count)
    );

    typedef struct {
        logic [63:0] price;
        logic [31:0] qty;
        logic [31:0] secid;
        logic [31:0] rptseq;
        logic [31:0] norders;
        logic [7:0]  level;
        logic [7:0]  act_byte;
        logic [7:0]  etype;
        logic [1:0]  exp_action;
    } ent_t;

    typedef struct {
        logic [15:0] blen;
        logic [7:0]  n;
        logic        sop;
        logic        eop;
        int          drain_beats;
        int          err_inc;
        int          msg_inc;
    } hdr_vec_t;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic             last;
        logic [63:0]      price;
        logic [31:0]      qty;
        logic [31:0]      secid;
        logic [31:0]      rptseq;
        logic [31:0]      norders;
        logic [7:0]       level;
        logic [1:0]       action;
        logic [7:0]       etype;
    } got_t;

    ent_t     tab [6];
    hdr_vec_t hv  [6];
    got_t     got [$];
    int       checks    = 0;
    int       errors    = 0;
    int       pulse_cnt = 0;
    int       exp_err   = 0;
    int       exp_msg   = 0;

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            got.push_back('{idx: out_idx, last: out_last, price: out_price, qty: out_qty,
                            secid: out_secid, rptseq: out_rptseq, norders: out_norders,
                            level: out_level, action: out_action, etype: out_etype});
        end
        if (!reset && err_pulse) pulse_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Little-endian wire encoding: wire byte k (bits 63-8k) carries value byte k.
    function automatic logic [63:0] le64(input logic [63:0] v);
        logic [63:0] w = '0;
        for (int k = 0; k < 8; k++) w[63-8*k -: 8] = v[8*k +: 8];
        return w;
    endfunction

    function automatic logic [31:0] le32(input logic [31:0] v);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w[31-8*k -: 8] = v[8*k +: 8];
        return w;
    endfunction

    function automatic logic [63:0] hdr(input logic [15:0] blen, input logic [7:0] n);
        return {blen[7:0], blen[15:8], n, 40'h0};
    endfunction

    function automatic logic [63:0] ent_beat(input int i, input int b);
        case (b)
            0:       return le64(tab[i].price);
            1:       return {le32(tab[i].qty), le32(tab[i].secid)};
            2:       return {le32(tab[i].rptseq), le32(tab[i].norders)};
            default: return {tab[i].level, tab[i].act_byte, tab[i].etype, 40'h0};
        endcase
    endfunction

    task automatic send(input logic sop, input logic eop, input logic [63:0] d);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_data  = d;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic send_entry(input int i, input logic eop);
        for (int b = 0; b < 4; b++) send(1'b0, (b == 3) && eop, ent_beat(i, b));
    endtask

    task automatic send_msg(input int n, input int base);
        send(1'b1, 1'b0, hdr(16'd32, 8'(n)));
        for (int i = 0; i < n; i++) send_entry((base + i) % 6, i == n - 1);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2;
        out_ready = v;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_recs(input int n);
        int guard = 0;
        while (got.size() < n && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        settle(3);
        check("rec_count", 64'(got.size()), 64'(n));
    endtask

    task automatic check_rec(input int k, input int ti, input int exp_idx, input logic exp_last);
        if (k < got.size()) begin
            check($sformatf("rec%0d_idx", k),     64'(got[k].idx),     64'(exp_idx));
            check($sformatf("rec%0d_last", k),    64'(got[k].last),    64'(exp_last));
            check($sformatf("rec%0d_price", k),   got[k].price,        tab[ti].price);
            check($sformatf("rec%0d_qty", k),     64'(got[k].qty),     64'(tab[ti].qty));
            check($sformatf("rec%0d_secid", k),   64'(got[k].secid),   64'(tab[ti].secid));
            check($sformatf("rec%0d_rptseq", k),  64'(got[k].rptseq),  64'(tab[ti].rptseq));
            check($sformatf("rec%0d_norders", k), 64'(got[k].norders), 64'(tab[ti].norders));
            check($sformatf("rec%0d_level", k),   64'(got[k].level),   64'(tab[ti].level));
            check($sformatf("rec%0d_action", k),  64'(got[k].action),  64'(tab[ti].exp_action));
            check($sformatf("rec%0d_etype", k),   64'(got[k].etype),   64'(tab[ti].etype));
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
        check({tag, "_err_pulses"}, 64'(pulse_cnt), 64'(exp_err));
        check({tag, "_msg_count"}, 64'(msg_count), 64'(exp_msg));
    endtask

    initial begin
        tab[0] = '{64'h0000_0000_05F5_E100, 32'h0000_0064, 32'h0000_1234, 32'h0102_0304,
                   32'h0000_0007, 8'h01, 8'h00, 8'h30, 2'd0};
        tab[1] = '{64'h1122_3344_5566_7788, 32'hDEAD_BEEF, 32'h0000_9999, 32'hA0B0_C0D0,
                   32'h0000_0010, 8'h0A, 8'h05, 8'h31, 2'd1};
        tab[2] = '{64'h8000_0000_0000_0001, 32'h0000_0001, 32'h0000_1234, 32'hFFFF_FFFF,
                   32'h0000_0000, 8'hFF, 8'hFE, 8'h45, 2'd2};
        tab[3] = '{64'h0123_4567_89AB_CDEF, 32'h0000_0200, 32'h0000_0042, 32'h0000_0100,
                   32'h0000_0003, 8'h02, 8'h01, 8'h32, 2'd1};
        tab[4] = '{64'hFEDC_BA98_7654_3210, 32'h0000_0300, 32'h0000_0043, 32'h0000_0101,
                   32'h0000_0004, 8'h03, 8'h02, 8'h33, 2'd2};
        tab[5] = '{64'h0000_0000_0000_0005, 32'h0000_0400, 32'h0000_0044, 32'h0000_0102,
                   32'h0000_0005, 8'h04, 8'h00, 8'h34, 2'd0};

        // {blen, n, sop, eop, drain_beats, err_inc, msg_inc}
        hv[0] = '{16'd32,    8'd0,  1'b1, 1'b1, 0, 0, 1};  // empty group, good message
        hv[1] = '{16'd32,    8'd0,  1'b1, 1'b0, 2, 1, 0};  // empty group without eop
        hv[2] = '{16'd24,    8'd2,  1'b1, 1'b1, 0, 1, 0};  // bad blockLength, eop on header
        hv[3] = '{16'h2000,  8'd1,  1'b1, 1'b1, 0, 1, 0};  // wire bytes 00 20: byte order
        hv[4] = '{16'd32,    8'd17, 1'b1, 1'b0, 5, 1, 0};  // NumInGroup > MAX_ENTRIES
        hv[5] = '{16'd32,    8'd0,  1'b0, 1'b1, 0, 0, 0};  // no sop in idle: dropped

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef MDP3_SECID_FILTER_EN
        cfg_filt_en = 1'b0;
        cfg_secid   = '0;
`endif
        settle(3);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_err_pulse", 64'(err_pulse), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_msg_count", 64'(msg_count), 64'd0);
        check("rst_out_price", out_price,      64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Header-only vectors
        for (int v = 0; v < 6; v++) begin
            send(hv[v].sop, hv[v].eop, hdr(hv[v].blen, hv[v].n));
            for (int b = 0; b < hv[v].drain_beats; b++)
                send(1'b0, b == hv[v].drain_beats - 1, hdr(16'd32, 8'd0));
            exp_err += hv[v].err_inc;
            exp_msg += hv[v].msg_inc;
            settle(3);
            check_counts($sformatf("hv%0d", v));
            check($sformatf("hv%0d_in_ready", v),  64'(in_ready),  64'd1);
            check($sformatf("hv%0d_out_valid", v), 64'(out_valid), 64'd0);
        end

        // Two-entry message with free-running consumer
        set_ready(1'b1);
        got.delete();
        send_msg(2, 0);
        exp_msg++;
        wait_recs(2);
        check_rec(0, 0, 0, 1'b0);
        check_rec(1, 1, 1, 1'b1);
        check_counts("n2");

        // Three more entry patterns
        got.delete();
        send_msg(3, 3);
        exp_msg++;
        wait_recs(3);
        for (int k = 0; k < 3; k++) check_rec(k, 3 + k, k, k == 2);

        // N=6 into a 4-deep FIFO with the consumer stalled
        set_ready(1'b0);
        got.delete();
        send(1'b1, 1'b0, hdr(16'd32, 8'd6));
        for (int i = 0; i < 4; i++) send_entry(i, 1'b0);
        for (int b = 0; b < 3; b++) send(1'b0, 1'b0, ent_beat(4, b));
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = ent_beat(4, 3);
        check("bp_stall_first", 64'(in_ready), 64'd0);
        settle(3);
        check("bp_stall_held",  64'(in_ready),  64'd0);
        check("bp_out_valid",   64'(out_valid), 64'd1);
        check("bp_head_idx",    64'(out_idx),   64'd0);
        check("bp_head_price",  out_price,      tab[0].price);
        set_ready(1'b1);
        send(1'b0, 1'b0, ent_beat(4, 3));
        send_entry(5, 1'b1);
        exp_msg++;
        wait_recs(6);
        for (int k = 0; k < 6; k++) check_rec(k, k, k, k == 5);
        check_counts("bp");

        // eop on beat 1 of entry 1 of an N=3 message
        got.delete();
        send(1'b1, 1'b0, hdr(16'd32, 8'd3));
        send_entry(0, 1'b0);
        send(1'b0, 1'b0, ent_beat(1, 0));
        send(1'b0, 1'b1, ent_beat(1, 1));
        exp_err++;
        wait_recs(1);
        check_rec(0, 0, 0, 1'b0);
        check_counts("early_eop");
        got.delete();
        send_msg(1, 2);
        exp_msg++;
        wait_recs(1);
        check_rec(0, 2, 0, 1'b1);
        check_counts("after_early_eop");

        // sop at beat 2 of entry 0: abort and restart on the same beat
        got.delete();
        send(1'b1, 1'b0, hdr(16'd32, 8'd2));
        send(1'b0, 1'b0, ent_beat(1, 0));
        send(1'b0, 1'b0, ent_beat(1, 1));
        send(1'b1, 1'b0, hdr(16'd32, 8'd1));
        send_entry(3, 1'b1);
        exp_err++;
        exp_msg++;
        wait_recs(1);
        check_rec(0, 3, 0, 1'b1);
        check_counts("mid_sop");

`ifdef MDP3_SECID_FILTER_EN
        cfg_filt_en = 1'b1;
        cfg_secid   = 32'h0000_1234;
        got.delete();
        send_msg(3, 0);
        exp_msg++;
        wait_recs(2);
        check_rec(0, 0, 0, 1'b0);
        check_rec(1, 2, 2, 1'b1);
        check("filt_count", 64'(filt_count), 64'd1);
        check_counts("filter");
        cfg_filt_en = 1'b0;
`endif

        // Reset mid-message with a record waiting in the FIFO
        set_ready(1'b0);
        got.delete();
        send(1'b1, 1'b0, hdr(16'd32, 8'd2));
        send_entry(0, 1'b0);
        send(1'b0, 1'b0, ent_beat(1, 0));
        @(negedge clk);
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_price", out_price,      64'd0);
        check("mid_rst_out_qty",   64'(out_qty),   64'd0);
        check("mid_rst_out_idx",   64'(out_idx),   64'd0);
        check("mid_rst_err_count", 64'(err_count), 64'd0);
        check("mid_rst_msg_count", 64'(msg_count), 64'd0);
        check("mid_rst_in_ready",  64'(in_ready),  64'd1);
        exp_err   = 0;
        exp_msg   = 0;
        pulse_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        set_ready(1'b1);
        send_msg(1, 5);
        exp_msg++;
        wait_recs(1);
        check_rec(0, 5, 0, 1'b1);
        check_counts("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
